// File: rtl/acia_seq_if.sv
// acia_seq_if -- bundle of the requester handshakes, the ACIA register bus
// and (when ACIA_SEQ_RX_EN is defined) the receive-data handshake.
//
// Modports:
//   master : the sequencer's view (drives readies, ACIA strobes, rx data)
//   slave  : the environment's view (requesters, ACIA device, rx consumer)
//
// Signals:
//   a_valid/a_data/a_ready   requester A TX byte handshake
//   b_valid/b_data/b_ready   requester B TX byte handshake
//   acia_cs/we/rs/din        ACIA register strobes and write data
//   acia_dout                ACIA read data, valid the cycle after a read
//   rx_valid/rx_data/rx_ready received-byte handshake (ACIA_SEQ_RX_EN only)
interface acia_seq_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       acia_cs;
  logic       acia_we;
  logic       acia_rs;
  logic [7:0] acia_din;
  logic [7:0] acia_dout;
`ifdef ACIA_SEQ_RX_EN
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    input  a_valid, a_data, b_valid, b_data, acia_dout, rx_ready,
    output a_ready, b_ready, acia_cs, acia_we, acia_rs, acia_din,
           rx_valid, rx_data
  );
  modport slave (
    output a_valid, a_data, b_valid, b_data, acia_dout, rx_ready,
    input  a_ready, b_ready, acia_cs, acia_we, acia_rs, acia_din,
           rx_valid, rx_data
  );
`else
  modport master (
    input  a_valid, a_data, b_valid, b_data, acia_dout,
    output a_ready, b_ready, acia_cs, acia_we, acia_rs, acia_din
  );
  modport slave (
    output a_valid, a_data, b_valid, b_data, acia_dout,
    input  a_ready, b_ready, acia_cs, acia_we, acia_rs, acia_din
  );
`endif
endinterface

// File: rtl/acia_seq.sv
// acia_seq -- initialises a 6850-style ACIA (master reset, then control
// word), then loops polling its status register. A received byte is pulled
// into a one-entry holding register when there is room; otherwise, when the
// transmitter is empty, one of two requesters is granted (round robin) and
// its byte is written to the TX data register.
//
// Optional feature macro: ACIA_SEQ_RX_EN (receive path, RX_R/RX_CAP states,
// rx_* handshake). Undefined: TX-only, status bit 0 ignored.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bus        acia_seq_if.master (requesters, ACIA bus, rx handshake)
//   init_done  high once the control word has been written
//   line_err   status bit 4 from the most recent status read
module acia_seq #(
  parameter logic [7:0] CTRL_WORD = 8'h15,
  parameter logic [7:0] MRST_WORD = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  acia_seq_if.master bus,
  output logic       init_done,
  output logic       line_err
);

  typedef enum logic [2:0] {
    S_MRST,
    S_CFG,
    S_POLL,
    S_STAT,
    S_DECIDE,
    S_TX_W
`ifdef ACIA_SEQ_RX_EN
    ,
    S_RX_R,
    S_RX_CAP
`endif
  } state_t;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } grant_t;

  state_t     state_q, state_d;
  logic [7:0] status_q;
  grant_t     last_grant_q;
  grant_t     grant_q;
  logic [7:0] tx_data_q;
  logic       take_tx;
  grant_t     pick;

  logic       cs_c, we_c, rs_c;
  logic [7:0] din_c;
  logic       a_ready_c, b_ready_c;

`ifdef ACIA_SEQ_RX_EN
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic       unused_status;
  assign unused_status = ^{status_q[7:5], status_q[3:2]};
`else
  logic       unused_status;
  assign unused_status = ^{status_q[7:5], status_q[3:2], status_q[0]};
`endif

  // A lone requester wins; on a tie the one not granted last wins.
  assign pick = (bus.b_valid && (!bus.a_valid || last_grant_q == GRANT_A))
              ? GRANT_B : GRANT_A;

  assign line_err = status_q[4];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_MRST;
      status_q     <= 8'h00;
      init_done    <= 1'b0;
      last_grant_q <= GRANT_B;
      grant_q      <= GRANT_A;
      tx_data_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == S_CFG)  init_done <= 1'b1;
      if (state_q == S_STAT) status_q  <= bus.acia_dout;
      // The byte is captured at the grant so a requester misbehaving after
      // DECIDE cannot change what TX_W writes.
      if (take_tx) begin
        grant_q      <= pick;
        last_grant_q <= pick;
        tx_data_q    <= (pick == GRANT_B) ? bus.b_data : bus.a_data;
      end
    end
  end

`ifdef ACIA_SEQ_RX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else if (state_q == S_RX_CAP) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= bus.acia_dout;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
`endif

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cs_c      = 1'b0;
    we_c      = 1'b0;
    rs_c      = 1'b0;
    din_c     = 8'h00;
    a_ready_c = 1'b0;
    b_ready_c = 1'b0;
    take_tx   = 1'b0;

    case (state_q)
      S_MRST: begin
        cs_c    = 1'b1;
        we_c    = 1'b1;
        din_c   = MRST_WORD;
        state_d = S_CFG;
      end
      S_CFG: begin
        cs_c    = 1'b1;
        we_c    = 1'b1;
        din_c   = CTRL_WORD;
        state_d = S_POLL;
      end
      S_POLL: begin
        cs_c    = 1'b1;
        state_d = S_STAT;
      end
      S_STAT: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        state_d = S_POLL;
`ifdef ACIA_SEQ_RX_EN
        // Receive first, but only when the holding register is free;
        // otherwise the byte waits inside the ACIA.
        if (status_q[0] && !rx_valid_q) state_d = S_RX_R;
        else
`endif
        if (status_q[1] && (bus.a_valid || bus.b_valid)) begin
          take_tx = 1'b1;
          state_d = S_TX_W;
        end
      end
      S_TX_W: begin
        cs_c      = 1'b1;
        we_c      = 1'b1;
        rs_c      = 1'b1;
        din_c     = tx_data_q;
        a_ready_c = (grant_q == GRANT_A);
        b_ready_c = (grant_q == GRANT_B);
        state_d   = S_POLL;
      end
`ifdef ACIA_SEQ_RX_EN
      S_RX_R: begin
        cs_c    = 1'b1;
        rs_c    = 1'b1;
        state_d = S_RX_CAP;
      end
      S_RX_CAP: begin
        state_d = S_POLL;
      end
`endif
      default: begin
        state_d = S_MRST;
      end
    endcase

    // Strobes and readies hold their reset values while rst is asserted,
    // including a cycle that was mid-TX_W when reset arrived.
    if (rst) begin
      cs_c      = 1'b0;
      we_c      = 1'b0;
      rs_c      = 1'b0;
      din_c     = 8'h00;
      a_ready_c = 1'b0;
      b_ready_c = 1'b0;
    end
  end

  assign bus.acia_cs  = cs_c;
  assign bus.acia_we  = we_c;
  assign bus.acia_rs  = rs_c;
  assign bus.acia_din = din_c;
  assign bus.a_ready  = a_ready_c;
  assign bus.b_ready  = b_ready_c;

endmodule

// File: tb/tb_acia_seq.sv
// tb_acia_seq -- self-checking bench for acia_seq. A small ACIA model
// answers reads one cycle later; requester queues feed A and B; expected TX
// writes are pushed to a scoreboard when stimulus is queued and popped by a
// monitor when the DUT writes the TX data register.
module tb_acia_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done;
  logic line_err;

  acia_seq_if bus ();

  acia_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .init_done (init_done),
    .line_err  (line_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_b;
    logic [7:0] data;
  } tx_t;

  int         checks = 0;
  int         errors = 0;
  tx_t        exp_q[$];
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] status_val = 8'h00;
  logic [7:0] rx_byte    = 8'h00;

  function automatic tx_t mk(input logic is_b, input logic [7:0] data);
    tx_t t;
    t.is_b = is_b;
    t.data = data;
    return t;
  endfunction

  // ACIA model: a read strobe returns status (rs=0) or RX data (rs=1)
  // on acia_dout during the following cycle.
  always @(posedge clk) begin
    if (bus.acia_cs && !bus.acia_we)
      bus.acia_dout <= bus.acia_rs ? rx_byte : status_val;
  end

  // Requester sources: present the head of each queue, retire it after the
  // cycle in which the matching ready was seen.
  initial begin
    bit acc_a, acc_b;
    bus.a_valid = 1'b0;
    bus.a_data  = 8'h00;
    bus.b_valid = 1'b0;
    bus.b_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc_a = bus.a_ready;
      acc_b = bus.b_ready;
      @(posedge clk);
      #1;
      if (acc_a && a_q.size() != 0) a_q.delete(0);
      if (acc_b && b_q.size() != 0) b_q.delete(0);
      bus.a_valid = (a_q.size() != 0);
      bus.a_data  = (a_q.size() != 0) ? a_q[0] : 8'h00;
      bus.b_valid = (b_q.size() != 0);
      bus.b_data  = (b_q.size() != 0) ? b_q[0] : 8'h00;
    end
  end

  // Monitor: scoreboard on TX writes plus per-cycle bus invariants.
  always @(negedge clk) begin : monitor
    tx_t e;
    if (bus.acia_cs && bus.acia_we && bus.acia_rs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: din=%h a_ready=%b b_ready=%b, required no TX write",
                 bus.acia_din, bus.a_ready, bus.b_ready);
      end else begin
        e = exp_q.pop_front();
        if (bus.acia_din !== e.data || bus.a_ready !== !e.is_b || bus.b_ready !== e.is_b) begin
          errors++;
          $display("FAIL tx_write: din=%h a_ready=%b b_ready=%b, required din=%h a_ready=%b b_ready=%b",
                   bus.acia_din, bus.a_ready, bus.b_ready, e.data, !e.is_b, e.is_b);
        end
      end
    end
    if (!rst) begin
      checks++;
      if ((bus.a_ready && bus.b_ready) ||
          ((bus.a_ready || bus.b_ready) && !(bus.acia_cs && bus.acia_we && bus.acia_rs)) ||
          (!bus.acia_we && bus.acia_din !== 8'h00)) begin
        errors++;
        $display("FAIL bus_invariant: cs=%b we=%b rs=%b din=%h a_ready=%b b_ready=%b, required single ready only in TX write and din=0 when we=0",
                 bus.acia_cs, bus.acia_we, bus.acia_rs, bus.acia_din, bus.a_ready, bus.b_ready);
      end
    end
  end

  task automatic reset_on();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Returns during cycle 0 (the first cycle with rst low).
  task automatic reset_off();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    status_val = 8'h00;
    reset_on();
    @(negedge clk);
    checks++;
    if ({bus.acia_cs, bus.acia_we, bus.acia_rs} !== 3'b000 || bus.acia_din !== 8'h00 ||
        bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || init_done !== 1'b0 || line_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: cs/we/rs=%b%b%b din=%h ready=%b%b init_done=%b line_err=%b, required all 0",
               bus.acia_cs, bus.acia_we, bus.acia_rs, bus.acia_din, bus.a_ready, bus.b_ready,
               init_done, line_err);
    end
`ifdef ACIA_SEQ_RX_EN
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx: rx_valid=%b rx_data=%h, required 0 and 00", bus.rx_valid, bus.rx_data);
    end
`endif
    reset_off();
    @(negedge clk);
    checks++;
    if ({bus.acia_cs, bus.acia_we, bus.acia_rs} !== 3'b110 || bus.acia_din !== 8'h03 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mrst_write: cs/we/rs=%b%b%b din=%h init_done=%b, required 110 din=03 init_done=0",
               bus.acia_cs, bus.acia_we, bus.acia_rs, bus.acia_din, init_done);
    end
    @(negedge clk);
    checks++;
    if ({bus.acia_cs, bus.acia_we, bus.acia_rs} !== 3'b110 || bus.acia_din !== 8'h15 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL cfg_write: cs/we/rs=%b%b%b din=%h init_done=%b, required 110 din=15 init_done=0",
               bus.acia_cs, bus.acia_we, bus.acia_rs, bus.acia_din, init_done);
    end
    @(negedge clk);
    checks++;
    if ({bus.acia_cs, bus.acia_we, bus.acia_rs} !== 3'b100 || bus.acia_din !== 8'h00 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL first_poll: cs/we/rs=%b%b%b din=%h init_done=%b, required 100 din=00 init_done=1",
               bus.acia_cs, bus.acia_we, bus.acia_rs, bus.acia_din, init_done);
    end
  endtask

  task automatic test_tx_single();
    int seen;
    int pulses;
    seen   = -1;
    pulses = 0;
    reset_on();
    status_val = 8'h02;
    a_q.push_back(8'h41);
    exp_q.push_back(mk(1'b0, 8'h41));
    reset_off();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.a_ready) pulses++;
      if (seen < 0 && bus.acia_cs && bus.acia_we && bus.acia_rs) seen = c;
    end
    checks++;
    if (seen != 5) begin
      errors++;
      $display("FAIL tx_latency: TX write at cycle %0d, required cycle 5", seen);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL a_ready_pulses: %0d pulses, required 1", pulses);
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || a_q.size() != 0) begin
      errors++;
      $display("FAIL tx_single_drain: %0d writes and %0d A bytes left, required 0 and 0",
               exp_q.size(), a_q.size());
    end
  endtask

  task automatic test_round_robin();
    reset_on();
    status_val = 8'h02;
    a_q.push_back(8'hA0);
    a_q.push_back(8'hA1);
    b_q.push_back(8'hB0);
    b_q.push_back(8'hB1);
    exp_q.push_back(mk(1'b0, 8'hA0));
    exp_q.push_back(mk(1'b1, 8'hB0));
    exp_q.push_back(mk(1'b0, 8'hA1));
    exp_q.push_back(mk(1'b1, 8'hB1));
    reset_off();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL round_robin_timeout: %0d writes outstanding, required 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      errors++;
      $display("FAIL round_robin_drain: A left %0d B left %0d, required 0 and 0", a_q.size(), b_q.size());
    end
  endtask

`ifdef ACIA_SEQ_RX_EN
  task automatic test_rx_priority();
    int rx_seen;
    int tx_seen;
    rx_seen = -1;
    tx_seen = -1;
    reset_on();
    bus.rx_ready = 1'b0;
    status_val = 8'h03;
    rx_byte    = 8'h5A;
    a_q.push_back(8'h41);
    exp_q.push_back(mk(1'b0, 8'h41));
    reset_off();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rx_seen < 0 && bus.acia_cs && !bus.acia_we && bus.acia_rs) rx_seen = c;
      if (tx_seen < 0 && bus.acia_cs && bus.acia_we && bus.acia_rs) tx_seen = c;
      if (c == 7) begin
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A) begin
          errors++;
          $display("FAIL rx_capture: rx_valid=%b rx_data=%h, required 1 and 5a", bus.rx_valid, bus.rx_data);
        end
      end
    end
    checks++;
    if (rx_seen != 5 || tx_seen != 10) begin
      errors++;
      $display("FAIL rx_first: RX read at %0d TX write at %0d, required 5 and 10", rx_seen, tx_seen);
    end
  endtask

  task automatic test_rx_hold();
    int reads;
    int seen;
    reads = 0;
    seen  = -1;
    status_val = 8'h01;
    rx_byte    = 8'h7E;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.acia_cs && !bus.acia_we && bus.acia_rs) reads++;
    end
    checks++;
    if (reads != 0 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL rx_hold: %0d RX reads rx_valid=%b rx_data=%h, required 0 reads 1 and 5a",
               reads, bus.rx_valid, bus.rx_data);
    end
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_consume: rx_valid=%b, required 0", bus.rx_valid);
    end
    for (int c = 0; c < 10 && seen < 0; c++) begin
      if (bus.acia_cs && !bus.acia_we && bus.acia_rs) seen = c;
      else @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (seen < 0 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h7E) begin
      errors++;
      $display("FAIL rx_resume: read seen=%0d rx_valid=%b rx_data=%h, required read, 1 and 7e",
               seen, bus.rx_valid, bus.rx_data);
    end
  endtask
`else
  task automatic test_status_rxf_ignored();
    int reads;
    int seen;
    reads = 0;
    seen  = -1;
    reset_on();
    status_val = 8'h03;
    a_q.push_back(8'h55);
    exp_q.push_back(mk(1'b0, 8'h55));
    reset_off();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.acia_cs && !bus.acia_we && bus.acia_rs) reads++;
      if (seen < 0 && bus.acia_cs && bus.acia_we && bus.acia_rs) seen = c;
    end
    checks++;
    if (reads != 0 || seen != 5) begin
      errors++;
      $display("FAIL rxf_ignored: %0d RX reads TX at cycle %0d, required 0 reads and cycle 5", reads, seen);
    end
  endtask
`endif

  task automatic test_line_err();
    status_val = 8'h10;
    repeat (8) @(negedge clk);
    checks++;
    if (line_err !== 1'b1) begin
      errors++;
      $display("FAIL line_err_set: line_err=%b, required 1", line_err);
    end
    status_val = 8'h00;
    repeat (8) @(negedge clk);
    checks++;
    if (line_err !== 1'b0) begin
      errors++;
      $display("FAIL line_err_clear: line_err=%b, required 0", line_err);
    end
  endtask

  task automatic test_reset_mid_tx();
    reset_on();
    status_val = 8'h02;
    a_q.push_back(8'hC3);
    reset_off();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;                      // cycle 5 is TX_W
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus.acia_cs, bus.acia_we, bus.acia_rs} !== 3'b000 || bus.a_ready !== 1'b0 ||
        bus.b_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_tx: cs/we/rs=%b%b%b ready=%b%b init_done=%b, required 000 00 0",
               bus.acia_cs, bus.acia_we, bus.acia_rs, bus.a_ready, bus.b_ready, init_done);
    end
    exp_q.push_back(mk(1'b0, 8'hC3));
    reset_off();
    @(negedge clk);
    checks++;
    if ({bus.acia_cs, bus.acia_we, bus.acia_rs} !== 3'b110 || bus.acia_din !== 8'h03) begin
      errors++;
      $display("FAIL mrst_reissue: cs/we/rs=%b%b%b din=%h, required 110 din=03",
               bus.acia_cs, bus.acia_we, bus.acia_rs, bus.acia_din);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL retx_after_reset: %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
`ifdef ACIA_SEQ_RX_EN
    bus.rx_ready = 1'b0;
`endif
    test_reset();
    test_tx_single();
    test_round_robin();
`ifdef ACIA_SEQ_RX_EN
    test_rx_priority();
    test_rx_hold();
`else
    test_status_rxf_ignored();
`endif
    test_line_err();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
